// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/flush handling, bubble insertion on
// upstream stalls, and saturating bubble/hold perf counters.
module pipe_stage_reg #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned WE_W         = 2,
    parameter int unsigned STALL_W      = 6,
    parameter int unsigned STAGE        = 3,
    parameter int unsigned ZERO_PAYLOAD = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [WE_W-1:0]    in_we,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    output logic [WE_W-1:0]    out_we,
    output logic [DATA_W-1:0]  out_data,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    generate
        if (STAGE >= STALL_W || DATA_W < 1 || WE_W < 1 || CNT_W < 2) begin : g_param_check
            $error("pipe_stage_reg: illegal parameter combination");
        end
    endgenerate

    logic up_stall;
    logic dn_stall;
    logic unused_stall;

    assign up_stall     = stall[STAGE];
    assign unused_stall = ^stall;

    // The last stage in the vector has no downstream stall source.
    generate
        if (STAGE + 1 < STALL_W) begin : g_dn_stall
            assign dn_stall = stall[STAGE+1];
        end else begin : g_no_dn_stall
            assign dn_stall = 1'b0;
        end
    endgenerate

    logic              valid_d;
    logic [WE_W-1:0]   we_d;
    logic [DATA_W-1:0] data_d;
    logic              bubble_inc;
    logic              hold_inc;
    logic [CNT_W-1:0]  bubble_d;
    logic [CNT_W-1:0]  hold_d;

    // Flush and bubble share the same output effect; only a bubble is counted.
    always_comb begin
        valid_d    = out_valid;
        we_d       = out_we;
        data_d     = out_data;
        bubble_inc = 1'b0;
        hold_inc   = 1'b0;
        if (flush || (up_stall && !dn_stall)) begin
            valid_d    = 1'b0;
            we_d       = '0;
            bubble_inc = !flush;
            if (ZERO_PAYLOAD != 0) begin
                data_d = '0;
            end
        end else if (!up_stall) begin
            valid_d = in_valid;
            we_d    = in_we & {WE_W{in_valid}};
            data_d  = in_data;
        end else begin
            hold_inc = 1'b1;
        end
    end

    // Clear wins over increment; increments stop at all-ones.
    always_comb begin
        bubble_d = bubble_cnt;
        hold_d   = hold_cnt;
        if (cnt_clr) begin
            bubble_d = '0;
            hold_d   = '0;
        end else begin
            if (bubble_inc && (bubble_cnt != {CNT_W{1'b1}})) begin
                bubble_d = bubble_cnt + CNT_W'(1);
            end
            if (hold_inc && (hold_cnt != {CNT_W{1'b1}})) begin
                hold_d = hold_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_we     <= '0;
            out_data   <= '0;
            bubble_cnt <= '0;
            hold_cnt   <= '0;
        end else begin
            out_valid  <= valid_d;
            out_we     <= we_d;
            out_data   <= data_d;
            bubble_cnt <= bubble_d;
            hold_cnt   <= hold_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three configurations (default, payload-hold,
// 2-bit counters) driven in lockstep against a rule-level reference model.
module tb_pipe_stage_reg;

    localparam int unsigned NCFG = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [1:0]  in_we;
    logic [31:0] in_data;
    logic        cnt_clr;

    logic [NCFG-1:0]        o_valid;
    logic [NCFG-1:0][1:0]   o_we;
    logic [NCFG-1:0][31:0]  o_data;
    logic [NCFG-1:0][15:0]  o_bub;
    logic [NCFG-1:0][15:0]  o_hold;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut_zero (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
        .out_valid(o_valid[0]), .out_we(o_we[0]), .out_data(o_data[0]),
        .cnt_clr(cnt_clr), .bubble_cnt(o_bub[0]), .hold_cnt(o_hold[0])
    );

    pipe_stage_reg #(.ZERO_PAYLOAD(0)) u_dut_keep (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
        .out_valid(o_valid[1]), .out_we(o_we[1]), .out_data(o_data[1]),
        .cnt_clr(cnt_clr), .bubble_cnt(o_bub[1]), .hold_cnt(o_hold[1])
    );

    pipe_stage_reg #(.CNT_W(2)) u_dut_small (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_data(in_data),
        .out_valid(o_valid[2]), .out_we(o_we[2]), .out_data(o_data[2]),
        .cnt_clr(cnt_clr), .bubble_cnt(o_bub[2][1:0]), .hold_cnt(o_hold[2][1:0])
    );
    assign o_bub[2][15:2]  = '0;
    assign o_hold[2][15:2] = '0;

    // Reference model: architectural state per configuration.
    bit          m_valid [NCFG];
    logic [1:0]  m_we    [NCFG];
    logic [31:0] m_data  [NCFG];
    int          m_bub   [NCFG];
    int          m_hold  [NCFG];
    int          zero_cfg[NCFG] = '{1, 0, 1};
    int          max_cfg [NCFG] = '{65535, 65535, 3};

    task automatic model_edge();
        bit up;
        bit dn;
        up = stall[3];
        dn = stall[4];
        for (int c = 0; c < NCFG; c++) begin
            if (!rst) begin
                m_valid[c] = 0; m_we[c] = 2'b00; m_data[c] = 32'h0;
                m_bub[c] = 0; m_hold[c] = 0;
            end else begin
                if (flush || (up && !dn)) begin
                    m_valid[c] = 0;
                    m_we[c]    = 2'b00;
                    if (zero_cfg[c] != 0) m_data[c] = 32'h0;
                    if (!flush && m_bub[c] < max_cfg[c]) m_bub[c] = m_bub[c] + 1;
                end else if (!up) begin
                    m_valid[c] = in_valid;
                    m_we[c]    = in_valid ? in_we : 2'b00;
                    m_data[c]  = in_data;
                end else if (m_hold[c] < max_cfg[c]) begin
                    m_hold[c] = m_hold[c] + 1;
                end
                if (cnt_clr) begin
                    m_bub[c]  = 0;
                    m_hold[c] = 0;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [5:0] s, input logic f,
                         input logic v, input logic [1:0] we, input logic [31:0] d,
                         input logic clr);
        rst = r; stall = s; flush = f; in_valid = v; in_we = we; in_data = d; cnt_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 6'b0, 1'b0, 1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 6'b0, 1'b0, 1'b1, 2'b11, 32'hDEAD_BEEF, 1'b0);
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (o_valid[c] !== 1'b0 || o_we[c] !== 2'b00 || o_data[c] !== 32'h0 ||
                o_bub[c] !== 16'h0 || o_hold[c] !== 16'h0) begin
                failures++;
                $display("FAIL reset cfg%0d: got v=%b we=%b d=%h bub=%0d hold=%0d, want all 0",
                         c, o_valid[c], o_we[c], o_data[c], o_bub[c], o_hold[c]);
            end
        end
    endtask

    task automatic test_advance();
        cycle(1'b1, 6'b0, 1'b0, 1'b1, 2'b11, 32'h1234_5678, 1'b0);
        checks++;
        if (o_valid[0] !== 1'b1 || o_we[0] !== 2'b11 || o_data[0] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL advance: got v=%b we=%b d=%h, want 1 11 12345678",
                     o_valid[0], o_we[0], o_data[0]);
        end
    endtask

    task automatic test_bubble();
        cycle(1'b1, 6'b001111, 1'b0, 1'b1, 2'b01, 32'hAAAA_5555, 1'b0);
        checks++;
        if (o_valid[0] !== 1'b0 || o_we[0] !== 2'b00 || o_data[0] !== 32'h0 || o_bub[0] !== 16'd1) begin
            failures++;
            $display("FAIL bubble_zero: got v=%b we=%b d=%h bub=%0d, want 0 00 0 1",
                     o_valid[0], o_we[0], o_data[0], o_bub[0]);
        end
        checks++;
        if (o_valid[1] !== 1'b0 || o_we[1] !== 2'b00 || o_data[1] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL bubble_keep: got v=%b we=%b d=%h, want 0 00 12345678",
                     o_valid[1], o_we[1], o_data[1]);
        end
    endtask

    task automatic test_hold();
        cycle(1'b1, 6'b0, 1'b0, 1'b1, 2'b11, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 6'b011111, 1'b0, 1'b1, 2'b10, 32'($urandom), 1'b0);
        end
        checks++;
        if (o_valid[0] !== 1'b1 || o_we[0] !== 2'b11 || o_data[0] !== 32'h1234_5678 ||
            o_hold[0] !== 16'd3 || o_bub[0] !== 16'd1) begin
            failures++;
            $display("FAIL hold: got v=%b we=%b d=%h hold=%0d bub=%0d, want 1 11 12345678 3 1",
                     o_valid[0], o_we[0], o_data[0], o_hold[0], o_bub[0]);
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 6'b011111, 1'b1, 1'b1, 2'b11, 32'h0BAD_F00D, 1'b0);
        checks++;
        if (o_valid[0] !== 1'b0 || o_we[0] !== 2'b00 || o_data[0] !== 32'h0 ||
            o_bub[0] !== 16'd1 || o_hold[0] !== 16'd3) begin
            failures++;
            $display("FAIL flush: got v=%b we=%b d=%h bub=%0d hold=%0d, want 0 00 0 1 3",
                     o_valid[0], o_we[0], o_data[0], o_bub[0], o_hold[0]);
        end
        checks++;
        if (o_data[1] !== 32'h1234_5678) begin
            failures++;
            $display("FAIL flush_keep: got d=%h, want 12345678", o_data[1]);
        end
        cycle(1'b1, 6'b0, 1'b0, 1'b0, 2'b11, 32'h5A5A_A5A5, 1'b0);
        checks++;
        if (o_valid[0] !== 1'b0 || o_we[0] !== 2'b00 || o_data[0] !== 32'h5A5A_A5A5) begin
            failures++;
            $display("FAIL invalid_we: got v=%b we=%b d=%h, want 0 00 5a5aa5a5",
                     o_valid[0], o_we[0], o_data[0]);
        end
    endtask

    task automatic test_saturate();
        cycle(1'b1, 6'b0, 1'b0, 1'b0, 2'b00, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 6'b001111, 1'b0, 1'b1, 2'b11, 32'($urandom), 1'b0);
        end
        checks++;
        if (o_bub[2] !== 16'd3 || o_bub[0] !== 16'd5) begin
            failures++;
            $display("FAIL bubble_sat: got small=%0d wide=%0d, want 3 5", o_bub[2], o_bub[0]);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 6'b111111, 1'b0, 1'b1, 2'b11, 32'($urandom), 1'b0);
        end
        checks++;
        if (o_hold[2] !== 16'd3 || o_hold[0] !== 16'd4) begin
            failures++;
            $display("FAIL hold_sat: got small=%0d wide=%0d, want 3 4", o_hold[2], o_hold[0]);
        end
        cycle(1'b1, 6'b001111, 1'b0, 1'b1, 2'b11, 32'h1, 1'b1);
        checks++;
        if (o_bub[2] !== 16'd0 || o_bub[0] !== 16'd0 || o_hold[2] !== 16'd0) begin
            failures++;
            $display("FAIL clr_over_inc: got small=%0d wide=%0d hold=%0d, want 0 0 0",
                     o_bub[2], o_bub[0], o_hold[2]);
        end
    endtask

    task automatic test_random();
        int k;
        for (int n = 0; n < 400; n++) begin
            k = $urandom_range(0, 6);
            cycle(($urandom_range(0, 39) != 0), 6'((1 << k) - 1), ($urandom_range(0, 7) == 0),
                  1'($urandom), 2'($urandom), 32'($urandom), ($urandom_range(0, 19) == 0));
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (o_valid[c] !== m_valid[c] || o_we[c] !== m_we[c] || o_data[c] !== m_data[c] ||
                    o_bub[c] !== 16'(m_bub[c]) || o_hold[c] !== 16'(m_hold[c])) begin
                    failures++;
                    $display("FAIL random n=%0d cfg%0d: got v=%b we=%b d=%h bub=%0d hold=%0d, want v=%b we=%b d=%h bub=%0d hold=%0d",
                             n, c, o_valid[c], o_we[c], o_data[c], o_bub[c], o_hold[c],
                             m_valid[c], m_we[c], m_data[c], m_bub[c], m_hold[c]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; in_valid = 1'b0;
        in_we = '0; in_data = '0; cnt_clr = 1'b0;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
